i2c_byte_ctrl: RTL and testbench

I2C_BYTE_CTRL -- requirements
Module: i2c_byte_ctrl

---
 rtl/i2c_byte_ctrl_if.sv | 26 ++
 rtl/i2c_byte_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_byte_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_byte_ctrl_if.sv
// Signal bundle between the host, i2c_byte_ctrl and the bit-level PHY.
// The DUT uses the slave modport; the host/PHY side uses the master modport.
interface i2c_byte_ctrl_if;
  logic       ena;
  logic       start, stop, read, write;
  logic       ack_in, hold;
  logic [7:0] din;
  logic       cmd_ack, ack_out;
  logic [7:0] dout;
  logic       i2c_busy, i2c_al;
  logic [3:0] core_cmd;
  logic       core_txd;
  logic       core_ack, core_rxd, core_al;

  modport slave (
    input  ena, start, stop, read, write, ack_in, hold, din,
    input  core_ack, core_rxd, core_al,
    output cmd_ack, ack_out, dout, i2c_busy, i2c_al, core_cmd, core_txd
  );

  modport master (
    output ena, start, stop, read, write, ack_in, hold, din,
    output core_ack, core_rxd, core_al,
    input  cmd_ack, ack_out, dout, i2c_busy, i2c_al, core_cmd, core_txd
  );
endinterface

// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C sequencer: turns host byte commands into PHY bit commands.
// Define I2C_BYTE_HOLD_EN to enable the post-byte bus-hold state (ST_HOLD).
module i2c_byte_ctrl (
  input  logic           clk,
  input  logic           rstn,
  i2c_byte_ctrl_if.slave bus
);
  localparam logic [3:0] I2C_CMD_NOP   = 4'h0;
  localparam logic [3:0] I2C_CMD_START = 4'h1;
  localparam logic [3:0] I2C_CMD_STOP  = 4'h2;
  localparam logic [3:0] I2C_CMD_WRITE = 4'h4;
  localparam logic [3:0] I2C_CMD_READ  = 4'h8;
`ifdef I2C_BYTE_HOLD_EN
  localparam logic [3:0] I2C_CMD_WAIT  = 4'h3;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5,
    ST_HOLD  = 3'd6
  } state_t;

  state_t     state_r, state_s;
  logic [3:0] cmd_r, cmd_s;
  logic       txd_r, txd_s;
  logic [7:0] sr_r, sr_s;
  logic [2:0] cnt_r, cnt_s;
  logic       cmd_ack_r, cmd_ack_s;
  logic       ack_out_r, ack_out_s;
  logic [7:0] dout_r, dout_s;
  logic       al_r, al_s;
  logic       al_pend_r, al_pend_s;
  logic       fin_s;

  // State and datapath registers; ena low freezes everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      cmd_r     <= I2C_CMD_NOP;
      txd_r     <= 1'b1;
      sr_r      <= 8'h00;
      cnt_r     <= 3'd0;
      cmd_ack_r <= 1'b0;
      ack_out_r <= 1'b0;
      dout_r    <= 8'h00;
      al_r      <= 1'b0;
      al_pend_r <= 1'b0;
    end else if (bus.ena) begin
      state_r   <= state_s;
      cmd_r     <= cmd_s;
      txd_r     <= txd_s;
      sr_r      <= sr_s;
      cnt_r     <= cnt_s;
      cmd_ack_r <= cmd_ack_s;
      ack_out_r <= ack_out_s;
      dout_r    <= dout_s;
      al_r      <= al_s;
      al_pend_r <= al_pend_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    cmd_s     = cmd_r;
    txd_s     = txd_r;
    sr_s      = sr_r;
    cnt_s     = cnt_r;
    cmd_ack_s = 1'b0;
    ack_out_s = ack_out_r;
    dout_s    = dout_r;
    al_s      = 1'b0;
    al_pend_s = 1'b0;
    fin_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // Launching is blocked while the previous sequence is still being acknowledged.
        if (!cmd_ack_r && !al_pend_r && (bus.start || bus.read || bus.write || bus.stop)) begin
          sr_s  = bus.din;
          cnt_s = 3'd7;
          txd_s = 1'b1;
          if (bus.start) begin
            state_s = ST_START;
            cmd_s   = I2C_CMD_START;
          end else if (bus.read) begin
            state_s = ST_READ;
            cmd_s   = I2C_CMD_READ;
          end else if (bus.write) begin
            state_s = ST_WRITE;
            cmd_s   = I2C_CMD_WRITE;
            txd_s   = bus.din[7];
          end else begin
            state_s = ST_STOP;
            cmd_s   = I2C_CMD_STOP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bus.core_ack) begin
          if (bus.read) begin
            state_s = ST_READ;
            cmd_s   = I2C_CMD_READ;
            txd_s   = 1'b1;
          end else if (bus.write) begin
            state_s = ST_WRITE;
            cmd_s   = I2C_CMD_WRITE;
            txd_s   = sr_r[7];
          end else begin
            fin_s = 1'b1;
          end
        end else begin
          state_s = ST_START;
        end
      end
      ST_WRITE, ST_READ: begin
        if (bus.core_ack) begin
          sr_s = {sr_r[6:0], bus.core_rxd};
          if (cnt_r == 3'd0) begin
            state_s = ST_ACK;
            if (state_r == ST_READ) begin
              cmd_s = I2C_CMD_WRITE;
              txd_s = bus.ack_in;
            end else begin
              cmd_s = I2C_CMD_READ;
              txd_s = 1'b1;
            end
          end else begin
            cnt_s = cnt_r - 3'd1;
            txd_s = (state_r == ST_WRITE) ? sr_s[7] : 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_ACK: begin
        if (bus.core_ack) begin
          ack_out_s = bus.core_rxd;
          dout_s    = sr_r;
          if (bus.stop) begin
            state_s = ST_STOP;
            cmd_s   = I2C_CMD_STOP;
            txd_s   = 1'b1;
          end else begin
            fin_s = 1'b1;
          end
        end else begin
          state_s = ST_ACK;
        end
      end
      ST_STOP: begin
        // A STOP completion never enters the hold state.
        if (bus.core_ack) begin
          state_s   = ST_IDLE;
          cmd_s     = I2C_CMD_NOP;
          txd_s     = 1'b1;
          cmd_ack_s = 1'b1;
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_HOLD: begin
        if (!bus.hold) begin
          state_s = ST_IDLE;
          cmd_s   = I2C_CMD_NOP;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cmd_s   = I2C_CMD_NOP;
        txd_s   = 1'b1;
      end
    endcase

    if (fin_s) begin
      state_s   = ST_IDLE;
      cmd_s     = I2C_CMD_NOP;
      txd_s     = 1'b1;
      cmd_ack_s = 1'b1;
`ifdef I2C_BYTE_HOLD_EN
      if (bus.hold) begin
        state_s = ST_HOLD;
        cmd_s   = I2C_CMD_WAIT;
      end else begin
        state_s = ST_IDLE;
      end
`endif
    end else begin
      cmd_ack_s = cmd_ack_s;
    end

    // Arbitration loss wins over everything; it is reported one cycle later.
    if (bus.core_al) begin
      state_s   = ST_IDLE;
      cmd_s     = I2C_CMD_NOP;
      txd_s     = 1'b1;
      cmd_ack_s = 1'b0;
      ack_out_s = ack_out_r;
      dout_s    = dout_r;
      al_pend_s = 1'b1;
    end else begin
      al_pend_s = 1'b0;
    end

    if (al_pend_r) begin
      al_s      = 1'b1;
      cmd_ack_s = 1'b1;
    end else begin
      al_s = 1'b0;
    end
  end

  assign bus.core_cmd = cmd_r;
  assign bus.core_txd = txd_r;
  assign bus.cmd_ack  = cmd_ack_r;
  assign bus.ack_out  = ack_out_r;
  assign bus.dout     = dout_r;
  assign bus.i2c_al   = al_r;
  assign bus.i2c_busy = (state_r != ST_IDLE);
endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Scoreboard bench for i2c_byte_ctrl: a 3-cycle-latency PHY model answers bit commands,
// a transaction-level model predicts bit sequences and byte results.
`timescale 1ns/1ps
module tb_i2c_byte_ctrl;
  localparam logic [3:0] C_NOP = 4'h0, C_START = 4'h1, C_STOP = 4'h2;
  localparam logic [3:0] C_WRITE = 4'h4, C_READ = 4'h8, C_WAIT = 4'h3;
`ifdef I2C_BYTE_HOLD_EN
  localparam logic [3:0] HOLD_CMD = C_WAIT;
  localparam logic       HOLD_BUSY = 1'b1;
`else
  localparam logic [3:0] HOLD_CMD = C_NOP;
  localparam logic       HOLD_BUSY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  i2c_byte_ctrl_if bus();
  i2c_byte_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [4:0] exp_bit_q[$];
  logic [9:0] exp_txn_q[$];
  bit         phy_rx_q[$];
  int         phy_wait = 0;
  int         phy_bits = 0;
  int         phy_al_at = -1;
  bit         ack_taken = 1'b0;
  int         bits_done = 0;
  logic       m_ack_out = 1'b0;
  logic [7:0] m_dout = 8'h00;
  logic [4:0] mon_b;
  logic [9:0] mon_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // PHY model: acknowledges each active bit command after 3 cycles.
  initial begin
    bus.core_ack = 1'b0;
    bus.core_rxd = 1'b0;
    bus.core_al  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        bus.core_ack = 1'b0;
        bus.core_al  = 1'b0;
        phy_wait = 0;
      end else if (bus.core_ack) begin
        if (ack_taken) begin
          bus.core_ack = 1'b0;
          bus.core_al  = 1'b0;
          phy_wait = 0;
        end
      end else if (bus.core_cmd inside {C_START, C_STOP, C_WRITE, C_READ}) begin
        phy_wait++;
        if (phy_wait == 3) begin
          bus.core_ack = 1'b1;
          if (bus.core_cmd == C_WRITE) bus.core_rxd = bus.core_txd;
          else if (bus.core_cmd == C_READ && phy_rx_q.size() > 0) bus.core_rxd = phy_rx_q.pop_front();
          else bus.core_rxd = 1'b1;
          if (bus.core_cmd == C_WRITE || bus.core_cmd == C_READ) begin
            if (phy_bits == phy_al_at) bus.core_al = 1'b1;
            phy_bits++;
          end
        end
      end else begin
        phy_wait = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    ack_taken = bus.core_ack && bus.ena;
  end

  // Monitor: compares each consumed bit command and each cmd_ack against the queues.
  initial forever begin
    @(negedge clk);
    #1;
    if (rstn && bus.core_ack && bus.ena) begin
      if (exp_bit_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL bit_unexpected: got cmd %0h expected none", bus.core_cmd);
      end else begin
        mon_b = exp_bit_q.pop_front();
        check("bit_cmd", bus.core_cmd, mon_b[4:1]);
        if (mon_b[4:1] == C_WRITE) check("bit_txd", bus.core_txd, mon_b[0]);
        bits_done++;
      end
    end
    if (rstn && bus.cmd_ack) begin
      if (exp_txn_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL cmd_ack_unexpected: got cmd_ack 1 expected 0 at %0t", $time);
      end else begin
        mon_t = exp_txn_q.pop_front();
        check("txn_al", bus.i2c_al, mon_t[9]);
        check("txn_ack_out", bus.ack_out, mon_t[8]);
        check("txn_dout", bus.dout, mon_t[7:0]);
      end
    end
  end

  // One host sequence; expectations are queued before the commands are driven.
  task automatic run_txn(input bit s, input bit r, input bit w, input bit p, input logic [7:0] d,
                         input bit ai, input logic [7:0] rx, input bit pa, input bit h, input int al_at);
    logic [4:0] q[$];
    logic       n_ack;
    logic [7:0] n_dout;
    int         k;
    bit         al_chk;
    n_ack = m_ack_out;
    n_dout = m_dout;
    phy_rx_q.delete();
    phy_bits = 0;
    phy_al_at = al_at;
    if (s) q.push_back({C_START, 1'b1});
    if (r) begin
      for (int i = 7; i >= 0; i--) begin
        q.push_back({C_READ, 1'b1});
        phy_rx_q.push_back(rx[i]);
      end
      q.push_back({C_WRITE, ai});
      n_ack = ai;
      n_dout = rx;
    end else if (w) begin
      for (int i = 7; i >= 0; i--) q.push_back({C_WRITE, d[i]});
      q.push_back({C_READ, 1'b1});
      phy_rx_q.push_back(pa);
      n_ack = pa;
      n_dout = d;
    end else if (!s && p) begin
      q.push_back({C_STOP, 1'b1});
    end
    if ((r || w) && p) q.push_back({C_STOP, 1'b1});
    if (al_at >= 0) begin
      while (q.size() > al_at + 1 + (s ? 1 : 0)) void'(q.pop_back());
      exp_txn_q.push_back({1'b1, m_ack_out, m_dout});
    end else begin
      m_ack_out = n_ack;
      m_dout = n_dout;
      exp_txn_q.push_back({1'b0, n_ack, n_dout});
    end
    foreach (q[i]) exp_bit_q.push_back(q[i]);

    @(negedge clk);
    bus.start = s; bus.read = r; bus.write = w; bus.stop = p;
    bus.din = d; bus.ack_in = ai; bus.hold = h;
    k = 0;
    al_chk = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (al_at >= 0 && !al_chk && !bus.i2c_busy && !bus.cmd_ack) begin
        check("al_idle_nop", bus.core_cmd, C_NOP);
        al_chk = 1'b1;
      end
    end while (!bus.cmd_ack && k < 3000);
    if (!bus.cmd_ack) begin
      n_chk++; n_fail++;
      $display("FAIL cmd_ack_timeout: got no cmd_ack expected one within 3000 cycles");
    end
    if (al_at >= 0) check("al_idle_seen", al_chk, 1'b1);
    bus.start = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.stop = 1'b0;
    if (h) begin
      for (int c = 0; c < 4; c++) begin
        check("hold_cmd", bus.core_cmd, HOLD_CMD);
        check("hold_busy", bus.i2c_busy, HOLD_BUSY);
        @(negedge clk);
      end
      bus.hold = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    check("after_cmd_ack", bus.cmd_ack, 1'b0);
    check("after_nop", bus.core_cmd, C_NOP);
    check("after_busy", bus.i2c_busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base;
    int         k;
    logic [3:0] c;
    logic [4:0] fb;
    bus.ena = 1'b1;
    bus.start = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.stop = 1'b0;
    bus.ack_in = 1'b0; bus.hold = 1'b0; bus.din = 8'h00;
    #23;
    check("rst_cmd", bus.core_cmd, C_NOP);
    check("rst_txd", bus.core_txd, 1'b1);
    check("rst_cmd_ack", bus.cmd_ack, 1'b0);
    check("rst_ack_out", bus.ack_out, 1'b0);
    check("rst_dout", bus.dout, 8'h00);
    check("rst_busy", bus.i2c_busy, 1'b0);
    check("rst_al", bus.i2c_al, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(1, 0, 1, 0, 8'hA5, 0, 8'h00, 0, 0, -1);
    run_txn(0, 1, 0, 1, 8'h00, 1, 8'h3C, 0, 0, -1);
    run_txn(0, 0, 1, 0, 8'h5A, 0, 8'h00, 0, 0, 4);

    // Freeze the core for 10 cycles after the third bit of a write.
    base = bits_done;
    fork
      run_txn(0, 0, 1, 1, 8'h96, 0, 8'h00, 1, 0, -1);
      begin
        k = 0;
        while (bits_done < base + 3 && k < 2000) begin @(negedge clk); k++; end
        @(negedge clk);
        bus.ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
          #1;
          fb = exp_bit_q[0];
          check("frz_cmd", bus.core_cmd, fb[4:1]);
          check("frz_txd", bus.core_txd, fb[0]);
          check("frz_busy", bus.i2c_busy, 1'b1);
          @(negedge clk);
        end
        bus.ena = 1'b1;
      end
    join

    run_txn(0, 0, 1, 0, 8'hC3, 0, 8'h00, 1, 1, -1);

    for (int t = 0; t < 10; t++) begin
      c = 4'($urandom_range(1, 15));
      run_txn(c[0], c[1], c[2], c[3], 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 0, -1);
    end
    check("bit_q_drained", exp_bit_q.size(), 0);
    check("txn_q_drained", exp_txn_q.size(), 0);

    // Asynchronous reset in the middle of a read byte.
    phy_rx_q.delete();
    phy_bits = 0;
    phy_al_at = -1;
    for (int i = 0; i < 8; i++) begin
      exp_bit_q.push_back({C_READ, 1'b1});
      phy_rx_q.push_back(1'b1);
    end
    base = bits_done;
    @(negedge clk);
    bus.read = 1'b1;
    k = 0;
    while (bits_done < base + 3 && k < 2000) begin @(negedge clk); k++; end
    check("rd_progress", (bits_done >= base + 3), 1'b1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_cmd", bus.core_cmd, C_NOP);
    check("arst_txd", bus.core_txd, 1'b1);
    check("arst_ack_out", bus.ack_out, 1'b0);
    check("arst_dout", bus.dout, 8'h00);
    check("arst_busy", bus.i2c_busy, 1'b0);
    check("arst_al", bus.i2c_al, 1'b0);
    bus.read = 1'b0;
    exp_bit_q.delete();
    phy_rx_q.delete();
    m_ack_out = 1'b0;
    m_dout = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_cmd_ack", bus.cmd_ack, 1'b0);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_no_cmd_ack", bus.cmd_ack, 1'b0);

    run_txn(1, 0, 1, 1, 8'h81, 0, 8'h00, 0, 0, -1);
    check("end_bit_q", exp_bit_q.size(), 0);
    check("end_txn_q", exp_txn_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
